// File: rtl/elec4700_pkg.sv
// Shared types, default programs and the 7-segment font for the two-core demo CPU.
package elec4700_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLdi  = 4'h1,
        OpAddi = 4'h2,
        OpSubi = 4'h3,
        OpAndi = 4'h4,
        OpOri  = 4'h5,
        OpXori = 4'h6,
        OpJmp  = 4'h7,
        OpJnz  = 4'h8,
        OpOut  = 4'h9,
        OpSt   = 4'hA,
        OpIn   = 4'hB,
        OpRsvC = 4'hC,
        OpRsvD = 4'hD,
        OpRsvE = 4'hE,
        OpHalt = 4'hF
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [7:0] imm;
    } instr_t;

    // Entry 0 sits in the least significant 12 bits.
    typedef instr_t [31:0] rom_t;

    // LDI 0; ADDI 1; OUT; ST 0; JMP 1; rest HALT
    localparam rom_t PROG0 = {{27{12'hF00}}, 12'h701, 12'hA00, 12'h900, 12'h201, 12'h100};
    // LDI FF; SUBI 1; OUT; ST 0; JMP 1; rest HALT
    localparam rom_t PROG1 = {{27{12'hF00}}, 12'h701, 12'hA00, 12'h900, 12'h301, 12'h1FF};

    // Active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/elec4700_core.sv
// 8-bit accumulator core with a 32-entry instruction ROM; stores stall until granted.
module elec4700_core
    import elec4700_pkg::*;
#(
    parameter rom_t Rom = PROG0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] sw_in_i,
    input  logic       gnt_i,
    output logic       req_o,
    output logic [7:0] addr_o,
    output logic [7:0] acc_o,
    output logic [7:0] out_o,
    output logic [4:0] pc_o,
    output logic       halted_o
);

    logic [4:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_q, out_d;
    logic       halted_q, halted_d;
    instr_t     instr;

    assign instr    = Rom[pc_q];
    assign addr_o   = instr.imm;
    assign acc_o    = acc_q;
    assign out_o    = out_q;
    assign pc_o     = pc_q;
    assign halted_o = halted_q;

    // Decode and execute the current instruction
    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        out_d    = out_q;
        halted_d = halted_q;
        req_o    = 1'b0;
        if (!halted_q) begin
            pc_d = pc_q + 5'd1;
            case (instr.op)
                OpLdi:  acc_d = instr.imm;
                OpAddi: acc_d = acc_q + instr.imm;
                OpSubi: acc_d = acc_q - instr.imm;
                OpAndi: acc_d = acc_q & instr.imm;
                OpOri:  acc_d = acc_q | instr.imm;
                OpXori: acc_d = acc_q ^ instr.imm;
                OpJmp:  pc_d = instr.imm[4:0];
                OpJnz:  if (acc_q != 8'h00) pc_d = instr.imm[4:0];
                OpOut:  out_d = acc_q;
                OpSt: begin
                    req_o = 1'b1;
                    if (!gnt_i) pc_d = pc_q;
                end
                OpIn:   acc_d = sw_in_i;
                OpHalt: begin
                    pc_d     = pc_q;
                    halted_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Core state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= 5'd0;
            acc_q    <= 8'h00;
            out_q    <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: rtl/elec4700.sv
// Board top: two cores, round-robin store arbiter, registered SSRAM control pins, LEDs and HEX.
// Optional build macro ELEC4700_HEX_PC_EN shows each core's pc on HEX3:HEX2 / HEX7:HEX6.
module elec4700
    import elec4700_pkg::*;
#(
    parameter rom_t ROM0 = PROG0,
    parameter rom_t ROM1 = PROG1
) (
    input  logic        clock,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [17:0] LEDR,
    output logic [8:0]  LEDG,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5,
    output logic [7:0]  HEX6,
    output logic [7:0]  HEX7,
    output logic        SRAM_CLK,
    output logic        SRAM_CE1_N,
    output logic        SRAM_CE2,
    output logic        SRAM_CE3_N,
    output logic [18:0] SRAM_A,
    output logic        SRAM_ADSC_N,
    output logic        SRAM_ADSP_N,
    output logic        SRAM_ADV_N,
    output logic        SRAM_GW_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_BE_N0,
    output logic        SRAM_BE_N1,
    output logic        SRAM_BE_N2,
    output logic        SRAM_BE_N3,
    output logic        SRAM_DPA0,
    output logic        SRAM_DPA1,
    output logic        SRAM_DPA2,
    output logic        SRAM_DPA3,
    output logic        SRAM_WE_N
);

    logic       rst;
    logic [1:0] req, gnt;
    logic [7:0] addr0, addr1, acc0, acc1, out0, out1;
    logic [4:0] pc0, pc1;
    logic       halted0, halted1;
    logic       last_q, last_d;     // 1: core1 was granted last
    logic [1:0] gnt_q, gnt_d;
    logic [18:0] a_q, a_d;
    logic       we_n_q, we_n_d;
    logic       dpa_q, dpa_d;
    logic       unused_inputs;

    assign rst           = SW[17];
    assign unused_inputs = ^{KEY, SW[16], pc0, pc1};

    elec4700_core #(.Rom(ROM0)) u_core0 (
        .clk_i    (clock),
        .rst_i    (rst),
        .sw_in_i  (SW[7:0]),
        .gnt_i    (gnt[0]),
        .req_o    (req[0]),
        .addr_o   (addr0),
        .acc_o    (acc0),
        .out_o    (out0),
        .pc_o     (pc0),
        .halted_o (halted0)
    );

    elec4700_core #(.Rom(ROM1)) u_core1 (
        .clk_i    (clock),
        .rst_i    (rst),
        .sw_in_i  (SW[15:8]),
        .gnt_i    (gnt[1]),
        .req_o    (req[1]),
        .addr_o   (addr1),
        .acc_o    (acc1),
        .out_o    (out1),
        .pc_o     (pc1),
        .halted_o (halted1)
    );

    // Round-robin arbiter and next values for the SSRAM pin registers
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        a_d    = 19'h0;
        we_n_d = 1'b1;
        dpa_d  = 1'b0;
        if (req[0] && req[1]) begin
            gnt    = last_q ? 2'b01 : 2'b10;
            last_d = ~last_q;
        end else if (req[0]) begin
            gnt    = 2'b01;
            last_d = 1'b0;
        end else if (req[1]) begin
            gnt    = 2'b10;
            last_d = 1'b1;
        end
        gnt_d = gnt;
        if (gnt[0]) begin
            a_d    = {1'b0, 10'b0, addr0};
            we_n_d = 1'b0;
            dpa_d  = ^acc0;
        end else if (gnt[1]) begin
            a_d    = {1'b1, 10'b0, addr1};
            we_n_d = 1'b0;
            dpa_d  = ^acc1;
        end
    end

    // Arbiter pointer, grant LEDs and SSRAM pin registers
    always_ff @(posedge clock) begin
        if (rst) begin
            last_q <= 1'b1;
            gnt_q  <= 2'b00;
            a_q    <= 19'h0;
            we_n_q <= 1'b1;
            dpa_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            gnt_q  <= gnt_d;
            a_q    <= a_d;
            we_n_q <= we_n_d;
            dpa_q  <= dpa_d;
        end
    end

    assign LEDR = {halted1, halted0, out1, out0};
    assign LEDG = {rst, 6'b0, gnt_q};

    assign HEX0 = {1'b1, hex7seg(out0[3:0])};
    assign HEX1 = {1'b1, hex7seg(out0[7:4])};
    assign HEX4 = {1'b1, hex7seg(out1[3:0])};
    assign HEX5 = {1'b1, hex7seg(out1[7:4])};
`ifdef ELEC4700_HEX_PC_EN
    assign HEX2 = {1'b1, hex7seg(pc0[3:0])};
    assign HEX3 = {1'b1, hex7seg({3'b0, pc0[4]})};
    assign HEX6 = {1'b1, hex7seg(pc1[3:0])};
    assign HEX7 = {1'b1, hex7seg({3'b0, pc1[4]})};
`else
    assign HEX2 = 8'hFF;
    assign HEX3 = 8'hFF;
    assign HEX6 = 8'hFF;
    assign HEX7 = 8'hFF;
`endif

    // Write strobes share one register: address strobe, byte enable and write enable coincide
    assign SRAM_CLK    = ~clock;
    assign SRAM_CE1_N  = 1'b0;
    assign SRAM_CE2    = 1'b1;
    assign SRAM_CE3_N  = 1'b0;
    assign SRAM_A      = a_q;
    assign SRAM_ADSC_N = we_n_q;
    assign SRAM_ADSP_N = 1'b1;
    assign SRAM_ADV_N  = 1'b1;
    assign SRAM_GW_N   = 1'b1;
    assign SRAM_OE_N   = 1'b1;
    assign SRAM_BE_N0  = we_n_q;
    assign SRAM_BE_N1  = 1'b1;
    assign SRAM_BE_N2  = 1'b1;
    assign SRAM_BE_N3  = 1'b1;
    assign SRAM_DPA0   = dpa_q;
    assign SRAM_DPA1   = 1'b0;
    assign SRAM_DPA2   = 1'b0;
    assign SRAM_DPA3   = 1'b0;
    assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_elec4700.sv
// Table-driven bench: default-program DUT plus a second DUT with custom ROMs.
module tb_elec4700;
    import elec4700_pkg::*;

    // dut_b core0: IN; OUT; HALT
    localparam rom_t ROM_B0 = {{29{12'hF00}}, 12'hF00, 12'h900, 12'hB00};
    // dut_b core1: LDI 02; ADDI FF; OUT; JNZ 6; LDI 77; OUT; SUBI 1; JNZ 4; LDI 3C; OUT; HALT
    localparam rom_t ROM_B1 = {{21{12'hF00}}, 12'hF00, 12'h900, 12'h13C, 12'h804, 12'h301,
                               12'h900, 12'h177, 12'h806, 12'h900, 12'h2FF, 12'h102};

    logic        clock = 1'b0;
    logic [17:0] sw;
    logic [3:0]  key = 4'h0;

    logic [17:0] ledr,   ledr_b;
    logic [8:0]  ledg,   ledg_b;
    logic [7:0]  hex [8];
    logic [7:0]  hex_b [8];
    logic [18:0] sram_a, sram_a_b;
    logic        we_n, we_n_b, dpa0, dpa0_b;
    logic        adsc_n, be_n0;
    logic [16:0] misc, misc_b;

    always #5 clock = ~clock;

    elec4700 dut (
        .clock(clock), .SW(sw), .KEY(key), .LEDR(ledr), .LEDG(ledg),
        .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]),
        .HEX4(hex[4]), .HEX5(hex[5]), .HEX6(hex[6]), .HEX7(hex[7]),
        .SRAM_CLK(misc[0]), .SRAM_CE1_N(misc[1]), .SRAM_CE2(misc[2]), .SRAM_CE3_N(misc[3]),
        .SRAM_A(sram_a), .SRAM_ADSC_N(adsc_n), .SRAM_ADSP_N(misc[4]), .SRAM_ADV_N(misc[5]),
        .SRAM_GW_N(misc[6]), .SRAM_OE_N(misc[7]), .SRAM_BE_N0(be_n0), .SRAM_BE_N1(misc[8]),
        .SRAM_BE_N2(misc[9]), .SRAM_BE_N3(misc[10]), .SRAM_DPA0(dpa0), .SRAM_DPA1(misc[11]),
        .SRAM_DPA2(misc[12]), .SRAM_DPA3(misc[13]), .SRAM_WE_N(we_n)
    );

    elec4700 #(.ROM0(ROM_B0), .ROM1(ROM_B1)) dut_b (
        .clock(clock), .SW(sw), .KEY(key), .LEDR(ledr_b), .LEDG(ledg_b),
        .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]), .HEX3(hex_b[3]),
        .HEX4(hex_b[4]), .HEX5(hex_b[5]), .HEX6(hex_b[6]), .HEX7(hex_b[7]),
        .SRAM_CLK(misc_b[0]), .SRAM_CE1_N(misc_b[1]), .SRAM_CE2(misc_b[2]),
        .SRAM_CE3_N(misc_b[3]), .SRAM_A(sram_a_b), .SRAM_ADSC_N(misc_b[14]),
        .SRAM_ADSP_N(misc_b[4]), .SRAM_ADV_N(misc_b[5]), .SRAM_GW_N(misc_b[6]),
        .SRAM_OE_N(misc_b[7]), .SRAM_BE_N0(misc_b[15]), .SRAM_BE_N1(misc_b[8]),
        .SRAM_BE_N2(misc_b[9]), .SRAM_BE_N3(misc_b[10]), .SRAM_DPA0(dpa0_b),
        .SRAM_DPA1(misc_b[11]), .SRAM_DPA2(misc_b[12]), .SRAM_DPA3(misc_b[13]),
        .SRAM_WE_N(we_n_b)
    );
    assign misc[16:14]   = 3'b0;
    assign misc_b[16]    = 1'b0;

    typedef struct packed {
        logic [17:0] ledr;
        logic [17:0] ledr_b;
        logic        we_n;
        logic [18:0] a;
        logic [1:0]  gnt;
        logic        dpa;
    } row_t;

    row_t tbl [0:10];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // Cycle k counts edges since reset release; row = state visible during that cycle
        tbl[0]  = '{18'h00000, 18'h00000, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[1]  = '{18'h00000, 18'h00000, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[2]  = '{18'h00000, 18'h000A5, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[3]  = '{18'h0FE01, 18'h101A5, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[4]  = '{18'h0FE01, 18'h101A5, 1'b0, 19'h00000, 2'b01, 1'b1};
        tbl[5]  = '{18'h0FE01, 18'h101A5, 1'b0, 19'h40000, 2'b10, 1'b1};
        tbl[6]  = '{18'h0FE01, 18'h101A5, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[7]  = '{18'h0FE02, 18'h101A5, 1'b1, 19'h00000, 2'b00, 1'b0};
        tbl[8]  = '{18'h0FD02, 18'h13CA5, 1'b0, 19'h00000, 2'b01, 1'b1};
        tbl[9]  = '{18'h0FD02, 18'h33CA5, 1'b0, 19'h40000, 2'b10, 1'b1};
        tbl[10] = '{18'h0FD02, 18'h33CA5, 1'b1, 19'h00000, 2'b00, 1'b0};

        // Reset for two cycles
        sw = 18'h200A5;
        tick(2);
        chk("rst ledr", 32'(ledr), 32'h0);
        chk("rst ledg", 32'(ledg), 32'h100);
        chk("rst hex0", 32'(hex[0]), 32'hC0);
        chk("rst hex1", 32'(hex[1]), 32'hC0);
        chk("rst hex4", 32'(hex[4]), 32'hC0);
        chk("rst we_n", 32'(we_n), 32'h1);
        chk("rst sram_a", 32'(sram_a), 32'h0);
        chk("rst dpa0", 32'(dpa0), 32'h0);
`ifdef ELEC4700_HEX_PC_EN
        chk("rst hex2", 32'(hex[2]), 32'hC0);
`else
        chk("rst hex2", 32'(hex[2]), 32'hFF);
`endif

        // Release and walk the table
        sw[17] = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            chk($sformatf("c%0d ledr", c), 32'(ledr), 32'(tbl[c].ledr));
            chk($sformatf("c%0d ledr_b", c), 32'(ledr_b), 32'(tbl[c].ledr_b));
            chk($sformatf("c%0d we_n", c), 32'(we_n), 32'(tbl[c].we_n));
            chk($sformatf("c%0d adsc_be", c), 32'({adsc_n, be_n0}), 32'({2{tbl[c].we_n}}));
            chk($sformatf("c%0d sram_a", c), 32'(sram_a), 32'(tbl[c].a));
            chk($sformatf("c%0d gnt", c), 32'(ledg[1:0]), 32'(tbl[c].gnt));
            chk($sformatf("c%0d dpa0", c), 32'(dpa0), 32'(tbl[c].dpa));
            chk($sformatf("c%0d we_n_b", c), 32'(we_n_b), 32'h1);
            if (c == 5) chk("c5 b core0 pc", 32'(dut_b.u_core0.pc_q), 32'd2);
            if (c < 10) tick(1);
        end
        chk("b hex1", 32'(hex_b[1]), 32'h88);
        chk("b hex0", 32'(hex_b[0]), 32'h92);
        chk("b hex5", 32'(hex_b[5]), 32'hB0);
        chk("b hex4", 32'(hex_b[4]), 32'hC6);
        chk("b core0 pc frozen", 32'(dut_b.u_core0.pc_q), 32'd2);
        chk("b core1 pc frozen", 32'(dut_b.u_core1.pc_q), 32'd10);

        // Reset while core1 is stalled on ST
        sw[17] = 1'b1;
        tick(1);
        sw[17] = 1'b0;
        tick(3);
        chk("stall core1 pc", 32'(dut.u_core1.pc_q), 32'd3);
        sw[17] = 1'b1;
        tick(1);
        chk("midrst core1 pc", 32'(dut.u_core1.pc_q), 32'd0);
        chk("midrst core0 pc", 32'(dut.u_core0.pc_q), 32'd0);
        chk("midrst we_n", 32'(we_n), 32'h1);
        chk("midrst ledr", 32'(ledr), 32'h0);
        sw[17] = 1'b0;
        tick(4);
        chk("post core0 first we_n", 32'(we_n), 32'h0);
        chk("post core0 first a", 32'(sram_a), 32'h00000);
        tick(1);
        chk("post core1 second a", 32'(sram_a), 32'h40000);
        tick(1);
        chk("post idle we_n", 32'(we_n), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
